// File: rtl/seq_sched_pkg.sv
// Shared types and constants for the sequence step scheduler.
// SEQ_SCHED_LOOP_EN selects endless auto rotation instead of a single pass.
package seq_sched_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StClear,
      StRun,
      StSwitch,
      StDone
   } sched_state_e;

   localparam logic [2:0] SEQ_SQRS = 3'd0;
   localparam logic [2:0] SEQ_EXP3 = 3'd1;
   localparam logic [2:0] SEQ_TRI  = 3'd2;
   localparam logic [2:0] SEQ_FIB  = 3'd3;
   localparam logic [2:0] SEQ_PELL = 3'd4;
   localparam logic [2:0] SEQ_LUC  = 3'd5;
   localparam logic [2:0] SEQ_PAD  = 3'd6;
   localparam logic [2:0] SEQ_SYLV = 3'd7;

`ifdef SEQ_SCHED_LOOP_EN
   localparam bit LOOP_EN = 1'b1;
`else
   localparam bit LOOP_EN = 1'b0;
`endif

endpackage

// File: rtl/seq_next_sel.sv
// Rotating-priority finder: first set mask bit strictly after idx_i, with idx_i itself last.
// wrapped_o flags a hit at or below idx_i, i.e. the search passed the top index.
module seq_next_sel #(
   parameter int unsigned NUM_SEQ = 8,
   parameter int unsigned SEL_W   = 3
) (
   input  logic [NUM_SEQ-1:0] mask_i,
   input  logic [SEL_W-1:0]   idx_i,
   output logic               found_o,
   output logic [SEL_W-1:0]   next_o,
   output logic               wrapped_o
);

   logic [SEL_W-1:0] cand;

   always_comb begin
      found_o   = 1'b0;
      next_o    = idx_i;
      wrapped_o = 1'b0;
      cand      = '0;
      // k == NUM_SEQ truncates to offset 0, so the current index is tried last
      for (int unsigned k = 1; k <= NUM_SEQ; k++) begin
         cand = idx_i + SEL_W'(k);
         if (!found_o && mask_i[cand]) begin
            found_o   = 1'b1;
            next_o    = cand;
            wrapped_o = (cand <= idx_i);
         end
      end
   end

endmodule

// File: rtl/seq_step_scheduler.sv
// Sequences the eight term generators: select, one-cycle clear and tick-gated step strobe.
// Define SEQ_SCHED_LOOP_EN to make auto mode rotate forever instead of stopping in DONE.
module seq_step_scheduler
   import seq_sched_pkg::*;
#(
   parameter int unsigned NUM_SEQ = 8,
   parameter int unsigned SEL_W   = 3,
   parameter int unsigned TERM_W  = 8
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               tick_i,
   input  logic               start_i,
   input  logic               stop_i,
   input  logic               auto_mode_i,
   input  logic [SEL_W-1:0]   manual_sel_i,
   input  logic [NUM_SEQ-1:0] enable_mask_i,
   input  logic [TERM_W-1:0]  terms_i,
   output logic [SEL_W-1:0]   sel_o,
   output logic               gen_clr_o,
   output logic               step_en_o,
   output logic [TERM_W-1:0]  term_idx_o,
   output logic               seq_switch_o,
   output logic               busy_o,
   output logic               done_o
);

   sched_state_e state_q, state_d;

   logic [SEL_W-1:0]  sel_q, sel_d;
   logic [TERM_W-1:0] term_idx_q, term_idx_d;
   logic              gen_clr_q, gen_clr_d;
   logic              step_en_q, step_en_d;
   logic              seq_switch_q, seq_switch_d;
   logic              busy_q, busy_d;
   logic              done_q, done_d;
   logic              auto_q, auto_d;

   logic [SEL_W-1:0]  find_idx;
   logic              find_found;
   logic [SEL_W-1:0]  find_next;
   logic              find_wrapped;

   // Searching after the top index yields the lowest set bit, which is what start needs
   assign find_idx = (state_q == StSwitch) ? sel_q : SEL_W'(NUM_SEQ - 1);

   seq_next_sel #(
      .NUM_SEQ (NUM_SEQ),
      .SEL_W   (SEL_W)
   ) u_next_sel (
      .mask_i    (enable_mask_i),
      .idx_i     (find_idx),
      .found_o   (find_found),
      .next_o    (find_next),
      .wrapped_o (find_wrapped)
   );

   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      term_idx_d = term_idx_q;
      auto_d     = auto_q;
      step_en_d  = 1'b0;

      unique case (state_q)
         StIdle, StDone: begin
            if (start_i) begin
               if (!auto_mode_i) begin
                  sel_d   = manual_sel_i;
                  auto_d  = 1'b0;
                  state_d = StClear;
               end else if (find_found) begin
                  sel_d   = find_next;
                  auto_d  = 1'b1;
                  state_d = StClear;
               end
            end
         end

         StClear: begin
            state_d = StRun;
         end

         StRun: begin
            if (!auto_q && (manual_sel_i != sel_q)) begin
               sel_d   = manual_sel_i;
               state_d = StClear;
            end else if (tick_i) begin
               step_en_d  = 1'b1;
               term_idx_d = term_idx_q + TERM_W'(1);
               // terms == 0 matches when the counter wraps, giving 2^TERM_W terms
               if (auto_q && (term_idx_d == terms_i)) begin
                  state_d = StSwitch;
               end
            end
         end

         StSwitch: begin
            if (!find_found) begin
               state_d = StIdle;
            end else if (find_wrapped && !LOOP_EN) begin
               state_d = StDone;
            end else begin
               sel_d   = find_next;
               state_d = StClear;
            end
         end

         default: begin
            state_d = StIdle;
         end
      endcase

      if (state_d == StClear) begin
         term_idx_d = '0;
      end

      if (stop_i) begin
         state_d    = StIdle;
         sel_d      = sel_q;
         term_idx_d = term_idx_q;
         auto_d     = auto_q;
         step_en_d  = 1'b0;
      end

      gen_clr_d    = (state_d == StClear);
      seq_switch_d = (state_d == StSwitch);
      busy_d       = (state_d == StClear) || (state_d == StRun) || (state_d == StSwitch);
      done_d       = (state_d == StDone);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= StIdle;
         sel_q        <= '0;
         term_idx_q   <= '0;
         gen_clr_q    <= 1'b0;
         step_en_q    <= 1'b0;
         seq_switch_q <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         auto_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         term_idx_q   <= term_idx_d;
         gen_clr_q    <= gen_clr_d;
         step_en_q    <= step_en_d;
         seq_switch_q <= seq_switch_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         auto_q       <= auto_d;
      end
   end

   assign sel_o        = sel_q;
   assign gen_clr_o    = gen_clr_q;
   assign step_en_o    = step_en_q;
   assign term_idx_o   = term_idx_q;
   assign seq_switch_o = seq_switch_q;
   assign busy_o       = busy_q;
   assign done_o       = done_q;

endmodule
